// File: rtl/mr_wb_arb_pkg.sv
// Shared definitions for the mr_wb_arb memory-side arbiter slice.
// Holds the data-path widths, the arbiter FSM state enum and the memory
// operation / size typedefs used by neighbouring load/store logic.
package mr_wb_arb_pkg;

    // Machine word width and the number of byte-offset bits dropped from
    // Wishbone word addresses.
    localparam int XLEN      = 32;
    localparam int XLEN_GRAN = $clog2(XLEN / 8);

    // Arbiter FSM states; encodings are stable so debug probes can decode them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } e_arbst;

    // Memory operation kinds issued by the pipeline masters.
    typedef enum logic [1:0] {
        MEMOP_FETCH = 2'd0,
        MEMOP_LOAD  = 2'd1,
        MEMOP_STORE = 2'd2,
        MEMOP_AMO   = 2'd3
    } e_memops;

    // Access sizes.
    typedef enum logic [1:0] {
        MEMSZ_B = 2'd0,
        MEMSZ_H = 2'd1,
        MEMSZ_W = 2'd2,
        MEMSZ_D = 2'd3
    } e_memsz;

    // Byte-lane select pattern for an aligned access of the given size.
    function automatic logic [XLEN/8-1:0] memsz_to_sel(input e_memsz sz);
        logic [XLEN/8-1:0] sel;
        sel = '0;
        case (sz)
            MEMSZ_B: sel = (XLEN/8)'(4'b0001);
            MEMSZ_H: sel = (XLEN/8)'(4'b0011);
            default: sel = '1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mr_wb_arb_outst_cnt.sv
// Outstanding-transfer counter for the Wishbone pipelined arbiter.
// Counts slave transfers accepted but not yet acknowledged; inc and dec in
// the same cycle cancel, dec while empty is ignored, clr wins over both.
module mr_outst_cnt
    import mr_wb_arb_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc,
    input  logic                         dec,
    input  logic                         clr,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(MAX_OUTST):0]   count
);

    localparam int CW = $clog2(MAX_OUTST) + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          inc_eff;
    logic          dec_eff;

    // Next count: abort clears, otherwise net of accepted and retired transfers.
    always_comb begin
        cnt_d   = cnt_q;
        inc_eff = inc && (cnt_q != MAX_C);
        dec_eff = dec && (cnt_q != '0);
        if (clr) begin
            cnt_d = '0;
        end else if (inc_eff && !dec_eff) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_eff && !inc_eff) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously so reset drops in-flight transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full  = (cnt_q == MAX_C);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/mr_wb_arb.sv
// Wishbone B4 pipelined 2:1 arbiter: m0 = instruction fetch, m1 = load/store.
// Build option: define MR_WB_ARB_RR_EN for round-robin on simultaneous
// requests; without it the load/store master (m1) always wins contention.
//
// Handshake: a request transfers on a cycle where stb is high and stall is
// low (s_stb_o && !s_stall_i on the slave side, mN_stb_i && !mN_stall_o on
// the master side); each transfer is retired by exactly one ack or err pulse.
// At most MAX_OUTST transfers may be accepted but unretired; beyond that the
// granted master is stalled. Dropping cyc aborts the cycle and forgets any
// transfers still outstanding, so late acks are swallowed.
module mr_wb_arb
    import mr_wb_arb_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    // master 0: instruction fetch
    input  logic [XLEN-XLEN_GRAN-1:0]   m0_adr_i,
    input  logic [XLEN-1:0]             m0_dat_i,
    output logic [XLEN-1:0]             m0_dat_o,
    input  logic                        m0_we_i,
    input  logic [XLEN/8-1:0]           m0_sel_i,
    input  logic                        m0_stb_i,
    input  logic                        m0_cyc_i,
    output logic                        m0_ack_o,
    output logic                        m0_err_o,
    output logic                        m0_stall_o,

    // master 1: load/store
    input  logic [XLEN-XLEN_GRAN-1:0]   m1_adr_i,
    input  logic [XLEN-1:0]             m1_dat_i,
    output logic [XLEN-1:0]             m1_dat_o,
    input  logic                        m1_we_i,
    input  logic [XLEN/8-1:0]           m1_sel_i,
    input  logic                        m1_stb_i,
    input  logic                        m1_cyc_i,
    output logic                        m1_ack_o,
    output logic                        m1_err_o,
    output logic                        m1_stall_o,

    // shared slave
    output logic [XLEN-XLEN_GRAN-1:0]   s_adr_o,
    output logic [XLEN-1:0]             s_dat_o,
    input  logic [XLEN-1:0]             s_dat_i,
    output logic                        s_we_o,
    output logic [XLEN/8-1:0]           s_sel_o,
    output logic                        s_stb_o,
    output logic                        s_cyc_o,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_stall_i,

    // debug visibility of the FSM and outstanding count
    output logic [1:0]                  dbg_state_o,
    output logic [$clog2(MAX_OUTST):0]  dbg_count_o
);

    e_arbst state_q;
    e_arbst state_d;

    logic   cnt_inc;
    logic   cnt_dec;
    logic   cnt_clr;
    logic   cnt_full;
    logic   cnt_empty;
    logic [$clog2(MAX_OUTST):0] cnt_val;

`ifdef MR_WB_ARB_RR_EN
    // 0 = m0 was granted most recently, 1 = m1; reset value hands m0 the
    // first contended grant.
    logic last_gnt_q;
    logic last_gnt_d;
`endif

    // Next-state: grant from IDLE, hold while granted cyc is high, hand over on release.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
`ifdef MR_WB_ARB_RR_EN
                    state_d = last_gnt_q ? GNT0 : GNT1;
`else
                    state_d = GNT1;
`endif
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    cnt_clr = 1'b1;
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    cnt_clr = 1'b1;
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MR_WB_ARB_RR_EN
    // Remember which master was granted last, updated on every grant entry.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_d == GNT0 && state_q != GNT0) begin
            last_gnt_d = 1'b0;
        end else if (state_d == GNT1 && state_q != GNT1) begin
            last_gnt_d = 1'b1;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // Slave-side mux and master-side response routing for the current grant.
    always_comb begin
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_we_o     = 1'b0;
        s_sel_o    = '0;
        s_stb_o    = 1'b0;
        s_cyc_o    = 1'b0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_stall_o = 1'b1;
        case (state_q)
            GNT0: begin
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                s_we_o     = m0_we_i;
                s_sel_o    = m0_sel_i;
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i && !cnt_full;
                m0_stall_o = s_stall_i || cnt_full;
                m0_ack_o   = s_ack_i && !cnt_empty;
                m0_err_o   = s_err_i && !cnt_empty;
            end
            GNT1: begin
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_we_o     = m1_we_i;
                s_sel_o    = m1_sel_i;
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i && !cnt_full;
                m1_stall_o = s_stall_i || cnt_full;
                m1_ack_o   = s_ack_i && !cnt_empty;
                m1_err_o   = s_err_i && !cnt_empty;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; only the granted master sees an ack qualify it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign cnt_inc = s_stb_o && !s_stall_i;
    assign cnt_dec = s_ack_i || s_err_i;

    mr_outst_cnt #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .clr   (cnt_clr),
        .full  (cnt_full),
        .empty (cnt_empty),
        .count (cnt_val)
    );

    assign dbg_state_o = state_q;
    assign dbg_count_o = cnt_val;

endmodule
